instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Owns the PC,

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to
// instruction memory, buffers responses in a small FIFO and presents
// {instr, pc, pc+4} to decode with a valid/ready handshake.
// Optional feature: define FETCH_PERF_CNT_EN to build the accepted-instruction
// counter on fetch_cnt_o. Without it, fetch_cnt_o is tied to zero.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] fetch_cnt_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop
    } state_e;

    state_e          state_q;
    logic            run_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     req_pc_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    logic            req_fire;
    logic            push;
    logic            pop;

    // A request needs a free slot for its response since only the FIFO can absorb it.
    // run_q keeps the request low during reset and the first cycle after release.
    assign imem_req_o  = run_q && (state_q == StReq) && !redirect_i && (count_q != DepthCnt);
    assign imem_addr_o = fetch_pc_q;
    assign req_fire    = imem_req_o & imem_ack_i;

    assign valid_o     = (count_q != '0);
    assign push        = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    assign pop         = valid_o && ready_i && !redirect_i;

    assign instr_o     = instr_mem[rd_ptr_q];
    assign pc_o        = pc_mem[rd_ptr_q];
    assign pc_plus4_o  = pc_o + 32'd4;

    // Fetch FSM and PC: redirect outranks everything and never issues a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            run_q <= 1'b1;
            if (redirect_i) begin
                fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
                case (state_q)
                    StReq:   state_q <= StReq;
                    // An outstanding response must still be swallowed.
                    StWait:  state_q <= imem_rvalid_i ? StReq : StDrop;
                    StDrop:  state_q <= imem_rvalid_i ? StReq : StDrop;
                    default: state_q <= StReq;
                endcase
            end else begin
                case (state_q)
                    StReq: begin
                        if (req_fire) begin
                            state_q    <= StWait;
                            req_pc_q   <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                        end
                    end
                    StWait:  if (imem_rvalid_i) state_q <= StReq;
                    StDrop:  if (imem_rvalid_i) state_q <= StReq;
                    default: state_q <= StReq;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_q so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= req_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Counts decode handshakes, including one that coincides with a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
        end else if (valid_o && ready_i) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`else
    assign fetch_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. A small memory model acks every request
// at once and returns the address as data after a programmable delay.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] fetch_cnt_o;

    instr_fetch #(
        .RESET_PC (32'h0040_0000),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory always accepts immediately.
    assign imem_ack_i = imem_req_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_hs = 0;
    int          exp_cnt = 0;
    int          rsp_delay = 1;
    int          wait_cnt = 0;
    bit          pending = 0;
    bit          stream_chk = 0;
    bit          last_acc = 0;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
        check_eq(tag, fetch_cnt_o, exp_cnt);
`else
        check_eq(tag, fetch_cnt_o, 32'h0);
`endif
    endtask

    // One clock: sample handshakes before the edge, update the memory model after it.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = imem_req_o & imem_ack_i;
        a   = imem_addr_o;
        if (valid_o && ready_i && rst_n) begin
            exp_cnt++;
            if (stream_chk) begin
                check_eq("instr", instr_o, exp_pc);
                check_eq("pc", pc_o, exp_pc);
                check_eq("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_hs++;
            end
        end
        @(posedge clk);
        #1;
        last_acc = acc;
        if (acc) last_acc_addr = a;
        imem_rvalid_i = 1'b0;
        if (acc) begin
            pending   = 1'b1;
            pend_addr = a;
            wait_cnt  = rsp_delay - 1;
        end
        if (pending) begin
            if (wait_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_addr;
                pending       = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic run_stream(input int n, input string tag);
        int target;
        int cyc;
        target     = n_hs + n;
        cyc        = 0;
        stream_chk = 1'b1;
        while (n_hs < target && cyc < 100) begin
            step();
            cyc++;
        end
        stream_chk = 1'b0;
        check_eq(tag, n_hs, target);
    endtask

    task automatic wait_acc();
        int k;
        k        = 0;
        last_acc = 1'b0;
        while (!last_acc && k < 20) begin
            step();
            k++;
        end
    endtask

    initial begin
        int k;
        rst_n         = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", valid_o, 1'b0);
        check_eq("rst_req", imem_req_o, 1'b0);
        check_eq("rst_addr", imem_addr_o, 32'h0040_0000);
        check_cnt("rst_cnt");
        rst_n = 1'b1;

        // Fill with decode stalled, then release
        wait_acc();
        check_eq("first_req_addr", last_acc_addr, 32'h0040_0000);
        repeat (10) step();
        check_eq("full_valid", valid_o, 1'b1);
        check_eq("full_req", imem_req_o, 1'b0);
        check_eq("hold_pc", pc_o, 32'h0040_0000);
        check_eq("hold_instr", instr_o, 32'h0040_0000);
        check_eq("hold_pc4", pc_plus4_o, 32'h0040_0004);
        ready_i = 1'b1;
        exp_pc  = 32'h0040_0000;
        run_stream(6, "stream_reset");
        check_cnt("cnt_after_stream");

        // Redirect while waiting; response arrives two cycles later and is dropped
        ready_i   = 1'b0;
        rsp_delay = 3;
        wait_acc();
        check_eq("s_wait_no_rvalid", imem_rvalid_i, 1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1003;
        step();
        redirect_i = 1'b0;
        #1;
        check_eq("drop_flushed", valid_o, 1'b0);
        check_eq("drop_no_req", imem_req_o, 1'b0);
        step();
        check_eq("drop_rvalid_req", imem_req_o, 1'b0);
        step();
        check_eq("redir_req", imem_req_o, 1'b1);
        check_eq("redir_addr", imem_addr_o, 32'h0000_1000);
        rsp_delay = 1;
        ready_i   = 1'b1;
        exp_pc    = 32'h0000_1000;
        run_stream(3, "stream_redir");

        // Redirect coinciding with a response and a decode handshake
        ready_i = 1'b0;
        k = 0;
        while (!(valid_o && imem_rvalid_i) && k < 20) begin
            step();
            k++;
        end
        check_eq("coincide_setup", valid_o & imem_rvalid_i, 1'b1);
        ready_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        stream_chk    = 1'b1;
        step();
        stream_chk = 1'b0;
        redirect_i = 1'b0;
        #1;
        check_eq("coincide_empty", valid_o, 1'b0);
        check_cnt("coincide_cnt");
        check_eq("coincide_req", imem_req_o, 1'b1);
        check_eq("coincide_addr", imem_addr_o, 32'h0000_2000);
        exp_pc = 32'h0000_2000;
        run_stream(3, "stream_coincide");

        // Redirect to the top of the address space; PC wraps to zero
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        exp_pc     = 32'hFFFF_FFFC;
        run_stream(3, "stream_wrap");
        check_cnt("cnt_after_wrap");

        // Reset in the middle of a wait, with a response arriving during reset
        ready_i   = 1'b0;
        rsp_delay = 2;
        wait_acc();
        rst_n         = 1'b0;
        pending       = 1'b0;
        exp_cnt       = 0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check_eq("mid_rst_valid", valid_o, 1'b0);
        check_eq("mid_rst_req", imem_req_o, 1'b0);
        check_cnt("mid_rst_cnt");
        step();
        check_eq("rst_no_push", valid_o, 1'b0);
        step();
        rst_n     = 1'b1;
        rsp_delay = 1;
        ready_i   = 1'b1;
        wait_acc();
        check_eq("rerst_addr", last_acc_addr, 32'h0040_0000);
        check_eq("lat_cycle1", valid_o, 1'b0);
        step();
        check_eq("lat_cycle2", valid_o, 1'b1);
        exp_pc = 32'h0040_0000;
        run_stream(3, "stream_rerst");
        check_cnt("cnt_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
